memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. It consumes the EX_MEM_* pipeline register and performs lw/sw through a req/ack data-memory handshake that can take several cycles. It produces the MEM_WB_* register and drives mem_stall_c back to EX, which holds EX_MEM_* while mem_stall_c is high. It also flags misaligned accesses and memory timeouts.

Parameters:
DATA_SIZE, 32, datapath width
ADDRESS_SIZE, 32, data-memory address width
ACK_TIMEOUT, 16, maximum cycles in WAIT without dmem_ack before the access is aborted (must be >= 1)

Ports:
clock  in  1  clock
reset_n  in  1  reset, synchronous, active-low
EX_MEM_valid  in  1  EX_MEM holds a real instruction
EX_MEM_op  in  6  opcode
EX_MEM_instruc_type  in  2  00 bubble, 01 J-type, 10 I-type, 11 R-type
EX_MEM_result  in  DATA_SIZE  ALU result, or effective address for lw/sw
EX_MEM_B  in  DATA_SIZE  forwarded rt value, used as store data
EX_MEM_dest  in  5  destination register
dmem_ack  in  1  memory completes the access this cycle
dmem_rdata  in  DATA_SIZE  load data, valid when dmem_ack is high
dmem_req  out  1  access request, registered
dmem_we  out  1  1 = store
dmem_addr  out  ADDRESS_SIZE  word address
dmem_wdata  out  DATA_SIZE  store data
mem_stall_c  out  1  combinational; EX and earlier stages hold while high
mem_fault_c  out  1  registered one-cycle pulse on misalign or timeout
MEM_WB_valid  out  1  WB must write MEM_WB_result to MEM_WB_dest
MEM_WB_dest  out  5  writeback register
MEM_WB_result  out  DATA_SIZE  writeback value
MEM_WB_op  out  6  opcode passed through
MEM_WB_instruc_type  out  2  instruction type passed through

Behaviour:
- Reset (reset_n low at a clock edge):
  - state = IDLE, timeout counter = 0.
  - All registered outputs go to 0: dmem_*, mem_fault_c, MEM_WB_*.
  - mem_stall_c is 0 while in reset.
- Decode:
  - is_mem = EX_MEM_valid && (op == lw || op == sw).
  - misaligned = EX_MEM_result[1:0] != 0.
  - writes_reg = EX_MEM_valid && type[1] && op not in {sw, beq} && EX_MEM_dest != 0.
- FSM states: IDLE, WAIT.
- IDLE, non-memory instruction or bubble:
  - mem_stall_c = 0.
  - Next edge: MEM_WB_valid <= writes_reg, MEM_WB_result <= EX_MEM_result, dest/op/type copied.
  - Latency is 1 cycle.
- IDLE, is_mem and misaligned:
  - No request issued, mem_stall_c = 0.
  - MEM_WB_valid <= 0; mem_fault_c high for exactly the next cycle.
  - The instruction is dropped.
- IDLE, is_mem and aligned:
  - mem_stall_c = 1.
  - Next edge: state <= WAIT, dmem_req <= 1, dmem_we <= (op == sw), dmem_addr <= EX_MEM_result, dmem_wdata <= EX_MEM_B, MEM_WB_valid <= 0 (bubble), counter <= 0.
- WAIT, dmem_ack = 1:
  - mem_stall_c = 0.
  - Next edge: state <= IDLE, dmem_req <= 0.
  - lw: MEM_WB_valid <= writes_reg, MEM_WB_result <= dmem_rdata.
  - sw: MEM_WB_valid <= 0, MEM_WB_result <= 0.
- WAIT, no ack, counter < ACK_TIMEOUT-1:
  - mem_stall_c = 1, counter increments, MEM_WB_valid <= 0.
- WAIT, no ack, counter == ACK_TIMEOUT-1:
  - Abort: mem_stall_c = 0.
  - Next edge: state <= IDLE, dmem_req <= 0, MEM_WB_valid <= 0, mem_fault_c pulses for one cycle.
- Stall count:
  - If ack arrives k cycles after dmem_req rises (k = 0 means the same cycle), mem_stall_c is high for exactly k+1 cycles.
  - On timeout, mem_stall_c is high for exactly ACK_TIMEOUT cycles.
- dmem_addr, dmem_we and dmem_wdata stay stable while dmem_req is high. dmem_req never re-asserts in the cycle right after an ack.
- dmem_ack while in IDLE (late or spurious) is ignored.
- Back-to-back memory ops: the new EX_MEM content appears after the ack edge and is evaluated in IDLE the same cycle. There is one request-free cycle between accesses.
- Reset during WAIT: state goes to IDLE and dmem_req drops at that edge. No fault pulse, no writeback.
- EX flushes EX_MEM on a taken branch or jump; the block needs no flush input.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants lw 6'h23, sw 6'h2B, beq 6'h04, j_inst 6'h02, add, ori, lui.
  - instruc_type encodings.
  - mem_state_t enum {IDLE, WAIT}.
- Sub-module dmem_handshake: owns the FSM, timeout counter, dmem_* registers, and the stall/fault generation. The parent holds the decode logic and the MEM_WB register.

Test Plan:
- add, EX_MEM_result = 0x5, dest = 3, type 11 -> next cycle MEM_WB_valid = 1, dest 3, result 0x5; mem_stall_c never high.
- lw, address 0x100, dest = 8, ack 3 cycles after req, rdata 0xDEADBEEF -> dmem_we = 0, mem_stall_c high 4 cycles, MEM_WB_valid = 1, dest 8, result 0xDEADBEEF, dmem_req low after the ack edge.
- sw, address 0x104, B = 0x12345678, ack same cycle as req -> dmem_we = 1, wdata 0x12345678, stall high 1 cycle, MEM_WB_valid = 0.
- lw, address 0x102 -> no dmem_req, mem_stall_c = 0, mem_fault_c single pulse next cycle, MEM_WB_valid = 0.
- ACK_TIMEOUT = 4, lw with no ack -> stall high 4 cycles, fault pulse, dmem_req drops, no writeback, later ack ignored.
- reset_n low during WAIT of a lw -> dmem_req = 0, stall = 0, outputs zero next cycle; ack after reset produces no writeback.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MIPS pipeline definitions: opcodes, instruction-type encodings and
// the MEM-stage handshake state type.
package cpu_pkg;

   // Opcodes seen by the MEM stage
   localparam logic [5:0] OP_ADD    = 6'h00;
   localparam logic [5:0] OP_J_INST = 6'h02;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // instruc_type encodings carried down the pipeline
   localparam logic [1:0] TYPE_BUBBLE = 2'b00;
   localparam logic [1:0] TYPE_J      = 2'b01;
   localparam logic [1:0] TYPE_I      = 2'b10;
   localparam logic [1:0] TYPE_R      = 2'b11;

   // Data-memory handshake states
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // True for opcodes that touch data memory
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack sequencer for the MEM stage. Issues one registered
// request per aligned lw/sw, holds address/data stable until ack or timeout,
// and generates the stall back to EX and the one-cycle fault pulse.
module dmem_handshake #(
   parameter int DATA_SIZE    = 32,
   parameter int ADDRESS_SIZE = 32,
   parameter int ACK_TIMEOUT  = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start_req,
   input  logic                    misalign,
   input  logic                    is_store,
   input  logic [ADDRESS_SIZE-1:0] req_addr,
   input  logic [DATA_SIZE-1:0]    req_wdata,
   input  logic                    dmem_ack,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output logic [ADDRESS_SIZE-1:0] dmem_addr,
   output logic [DATA_SIZE-1:0]    dmem_wdata,
   output logic                    mem_stall_c,
   output logic                    mem_fault_c,
   output logic                    in_wait,
   output logic                    mem_done
);
   import cpu_pkg::*;

   // Counter must hold 0..ACK_TIMEOUT-1; keep at least one bit for ACK_TIMEOUT == 1
   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   mem_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             stall_raw;
   logic             issue;
   logic             fault_nxt;

   assign in_wait  = (state == WAIT);
   assign mem_done = (state == WAIT) && dmem_ack;

   // Stall is forced low while reset is asserted
   assign mem_stall_c = reset_n && stall_raw;

   // Next-state, counter, stall and fault decisions
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_raw = 1'b0;
      issue     = 1'b0;
      fault_nxt = 1'b0;
      case (state)
         IDLE: begin
            // Any ack seen here is late or spurious and is ignored
            if (start_req) begin
               stall_raw = 1'b1;
               issue     = 1'b1;
               state_nxt = WAIT;
               cnt_nxt   = '0;
            end else if (misalign) begin
               fault_nxt = 1'b1;
            end
         end
         WAIT: begin
            // Ack takes priority over a timeout in the same cycle
            if (dmem_ack) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               fault_nxt = 1'b1;
            end else begin
               stall_raw = 1'b1;
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counter and dmem_* registers; address/data only load on issue
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         mem_fault_c <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         dmem_req    <= (state_nxt == WAIT);
         mem_fault_c <= fault_nxt;
         if (issue) begin
            dmem_we    <= is_store;
            dmem_addr  <= req_addr;
            dmem_wdata <= req_wdata;
         end
      end
   end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: decodes EX_MEM, runs lw/sw through
// the data-memory handshake and produces the MEM_WB register.
module memory_stage #(
   parameter int DATA_SIZE    = 32,
   parameter int ADDRESS_SIZE = 32,
   parameter int ACK_TIMEOUT  = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    EX_MEM_valid,
   input  logic [5:0]              EX_MEM_op,
   input  logic [1:0]              EX_MEM_instruc_type,
   input  logic [DATA_SIZE-1:0]    EX_MEM_result,
   input  logic [DATA_SIZE-1:0]    EX_MEM_B,
   input  logic [4:0]              EX_MEM_dest,
   input  logic                    dmem_ack,
   input  logic [DATA_SIZE-1:0]    dmem_rdata,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output logic [ADDRESS_SIZE-1:0] dmem_addr,
   output logic [DATA_SIZE-1:0]    dmem_wdata,
   output logic                    mem_stall_c,
   output logic                    mem_fault_c,
   output logic                    MEM_WB_valid,
   output logic [4:0]              MEM_WB_dest,
   output logic [DATA_SIZE-1:0]    MEM_WB_result,
   output logic [5:0]              MEM_WB_op,
   output logic [1:0]              MEM_WB_instruc_type
);
   import cpu_pkg::*;

   logic is_mem;
   logic misaligned;
   logic is_store;
   logic writes_reg;
   logic in_wait;
   logic mem_done;

   assign is_mem     = EX_MEM_valid && is_mem_op(EX_MEM_op);
   assign misaligned = (EX_MEM_result[1:0] != 2'b00);
   assign is_store   = (EX_MEM_op == OP_SW);
   // Only I/R-type instructions write a register; sw and beq never do, and r0 is discarded
   assign writes_reg = EX_MEM_valid && EX_MEM_instruc_type[1] &&
                       (EX_MEM_op != OP_SW) && (EX_MEM_op != OP_BEQ) &&
                       (EX_MEM_dest != 5'd0);

   dmem_handshake #(
      .DATA_SIZE    (DATA_SIZE),
      .ADDRESS_SIZE (ADDRESS_SIZE),
      .ACK_TIMEOUT  (ACK_TIMEOUT)
   ) u_handshake (
      .clock       (clock),
      .reset_n     (reset_n),
      .start_req   (is_mem && !misaligned),
      .misalign    (is_mem && misaligned),
      .is_store    (is_store),
      .req_addr    (ADDRESS_SIZE'(EX_MEM_result)),
      .req_wdata   (EX_MEM_B),
      .dmem_ack    (dmem_ack),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .mem_stall_c (mem_stall_c),
      .mem_fault_c (mem_fault_c),
      .in_wait     (in_wait),
      .mem_done    (mem_done)
   );

   // MEM_WB register: ALU results pass in one cycle, loads complete on ack,
   // everything else (issue, wait, misalign, timeout) inserts a bubble
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         MEM_WB_valid        <= 1'b0;
         MEM_WB_dest         <= '0;
         MEM_WB_result       <= '0;
         MEM_WB_op           <= '0;
         MEM_WB_instruc_type <= '0;
      end else begin
         MEM_WB_dest         <= EX_MEM_dest;
         MEM_WB_op           <= EX_MEM_op;
         MEM_WB_instruc_type <= EX_MEM_instruc_type;
         if (mem_done) begin
            MEM_WB_valid  <= writes_reg;
            MEM_WB_result <= is_store ? '0 : dmem_rdata;
         end else if (!in_wait && !is_mem) begin
            MEM_WB_valid  <= writes_reg;
            MEM_WB_result <= EX_MEM_result;
         end else begin
            MEM_WB_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: transaction-level expectations
// derived per instruction, compared against the DUT every cycle.
module tb_memory_stage;
   import cpu_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          EX_MEM_valid;
   logic [5:0]    EX_MEM_op;
   logic [1:0]    EX_MEM_instruc_type;
   logic [DW-1:0] EX_MEM_result;
   logic [DW-1:0] EX_MEM_B;
   logic [4:0]    EX_MEM_dest;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          mem_stall_c;
   logic          mem_fault_c;
   logic          MEM_WB_valid;
   logic [4:0]    MEM_WB_dest;
   logic [DW-1:0] MEM_WB_result;
   logic [5:0]    MEM_WB_op;
   logic [1:0]    MEM_WB_instruc_type;

   memory_stage #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW), .ACK_TIMEOUT(TO)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .EX_MEM_valid        (EX_MEM_valid),
      .EX_MEM_op           (EX_MEM_op),
      .EX_MEM_instruc_type (EX_MEM_instruc_type),
      .EX_MEM_result       (EX_MEM_result),
      .EX_MEM_B            (EX_MEM_B),
      .EX_MEM_dest         (EX_MEM_dest),
      .dmem_ack            (dmem_ack),
      .dmem_rdata          (dmem_rdata),
      .dmem_req            (dmem_req),
      .dmem_we             (dmem_we),
      .dmem_addr           (dmem_addr),
      .dmem_wdata          (dmem_wdata),
      .mem_stall_c         (mem_stall_c),
      .mem_fault_c         (mem_fault_c),
      .MEM_WB_valid        (MEM_WB_valid),
      .MEM_WB_dest         (MEM_WB_dest),
      .MEM_WB_result       (MEM_WB_result),
      .MEM_WB_op           (MEM_WB_op),
      .MEM_WB_instruc_type (MEM_WB_instruc_type)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;
   int stall_seen  = 0;

   // Expectations for the current cycle (e_) and for after the next edge (n_)
   logic          e_stall, e_req, e_we, e_fault, e_wbv, e_dm_chk, e_chk_res, e_chk_meta;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_result;
   logic [4:0]    e_dest;
   logic [5:0]    e_op;
   logic [1:0]    e_type;
   logic          n_req, n_we, n_fault, n_wbv, n_dm_chk, n_chk_res, n_chk_meta;
   logic [AW-1:0] n_addr;
   logic [DW-1:0] n_wdata, n_result;
   logic [4:0]    n_dest;
   logic [5:0]    n_op;
   logic [1:0]    n_type;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("mem_stall_c", 32'(mem_stall_c), 32'(e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      chk("mem_fault_c", 32'(mem_fault_c), 32'(e_fault));
      chk("MEM_WB_valid", 32'(MEM_WB_valid), 32'(e_wbv));
      if (e_dm_chk) begin
         chk("dmem_we", 32'(dmem_we), 32'(e_we));
         chk("dmem_addr", 32'(dmem_addr), 32'(e_addr));
         chk("dmem_wdata", 32'(dmem_wdata), 32'(e_wdata));
      end
      if (e_chk_res) chk("MEM_WB_result", 32'(MEM_WB_result), 32'(e_result));
      if (e_chk_meta) begin
         chk("MEM_WB_dest", 32'(MEM_WB_dest), 32'(e_dest));
         chk("MEM_WB_op", 32'(MEM_WB_op), 32'(e_op));
         chk("MEM_WB_instruc_type", 32'(MEM_WB_instruc_type), 32'(e_type));
      end
      if (mem_stall_c === 1'b1) stall_seen++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
      e_req = n_req;  e_we = n_we;  e_addr = n_addr;  e_wdata = n_wdata;
      e_fault = n_fault;  e_wbv = n_wbv;  e_result = n_result;  e_dest = n_dest;
      e_op = n_op;  e_type = n_type;  e_dm_chk = n_dm_chk;
      e_chk_res = n_chk_res;  e_chk_meta = n_chk_meta;
   endtask

   task automatic next_idle();
      n_req = 1'b0;  n_fault = 1'b0;  n_wbv = 1'b0;
      n_dm_chk = 1'b0;  n_chk_res = 1'b0;  n_chk_meta = 1'b0;
   endtask

   task automatic next_reset();
      n_req = 1'b0;  n_we = 1'b0;  n_addr = '0;  n_wdata = '0;  n_fault = 1'b0;
      n_wbv = 1'b0;  n_result = '0;  n_dest = '0;  n_op = '0;  n_type = '0;
      n_dm_chk = 1'b1;  n_chk_res = 1'b1;  n_chk_meta = 1'b1;
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         reset_n = 1'b0;
         EX_MEM_valid = 1'($urandom_range(0, 1));
         EX_MEM_op = OP_LW;  EX_MEM_instruc_type = TYPE_I;
         EX_MEM_result = $urandom & 32'hFFFF_FFFC;  EX_MEM_B = $urandom;
         EX_MEM_dest = 5'($urandom);
         dmem_ack = 1'($urandom_range(0, 1));  dmem_rdata = $urandom;
         e_stall = 1'b0;
         next_reset();
      end
   endtask

   // One IDLE cycle of a non-memory instruction or bubble
   task automatic alu_cycle(input logic v, input logic [5:0] op, input logic [1:0] typ,
                            input logic [31:0] res, input logic [4:0] dest, input logic ack);
      tick();
      reset_n = 1'b1;
      EX_MEM_valid = v;  EX_MEM_op = op;  EX_MEM_instruc_type = typ;
      EX_MEM_result = res;  EX_MEM_B = $urandom;  EX_MEM_dest = dest;
      dmem_ack = ack;  dmem_rdata = $urandom;
      e_stall = 1'b0;
      next_idle();
      n_wbv = v && typ[1] && (op != OP_SW) && (op != OP_BEQ) && (dest != 5'd0);
      n_result = res;  n_dest = dest;  n_op = op;  n_type = typ;
      n_chk_res = 1'b1;  n_chk_meta = 1'b1;
   endtask

   task automatic bubble(input logic ack);
      alu_cycle(1'b0, OP_ADD, TYPE_BUBBLE, $urandom, 5'd0, ack);
   endtask

   // Whole lw/sw transaction; k = cycles after req rises until ack (k >= TO: never)
   task automatic mem_op(input logic store, input logic [31:0] addr, input logic [31:0] b,
                         input logic [4:0] dest, input int k, input logic [31:0] rdata,
                         input logic idle_ack);
      tick();
      reset_n = 1'b1;
      EX_MEM_valid = 1'b1;  EX_MEM_op = store ? OP_SW : OP_LW;  EX_MEM_instruc_type = TYPE_I;
      EX_MEM_result = addr;  EX_MEM_B = b;  EX_MEM_dest = dest;
      dmem_ack = idle_ack;  dmem_rdata = $urandom;
      next_idle();
      if (addr[1:0] != 2'b00) begin
         e_stall = 1'b0;
         n_fault = 1'b1;
         return;
      end
      e_stall = 1'b1;
      n_req = 1'b1;  n_dm_chk = 1'b1;  n_we = store;  n_addr = addr;  n_wdata = b;
      for (int w = 0; w < TO; w++) begin
         tick();
         dmem_rdata = $urandom;
         next_idle();
         if (w == k) begin
            dmem_ack = 1'b1;  dmem_rdata = rdata;
            e_stall = 1'b0;
            n_wbv = !store && (dest != 5'd0);
            n_result = store ? 32'h0 : rdata;
            n_dest = dest;  n_op = EX_MEM_op;  n_type = TYPE_I;
            n_chk_res = 1'b1;  n_chk_meta = !store;
            return;
         end
         dmem_ack = 1'b0;
         if (w == TO - 1) begin
            e_stall = 1'b0;
            n_fault = 1'b1;
            return;
         end
         e_stall = 1'b1;
         n_req = 1'b1;  n_dm_chk = 1'b1;
      end
   endtask

   // lw whose WAIT is cut short by reset in wait cycle r (r <= TO-2)
   task automatic mem_reset(input logic [31:0] addr, input logic [4:0] dest, input int r);
      tick();
      reset_n = 1'b1;
      EX_MEM_valid = 1'b1;  EX_MEM_op = OP_LW;  EX_MEM_instruc_type = TYPE_I;
      EX_MEM_result = addr;  EX_MEM_B = $urandom;  EX_MEM_dest = dest;
      dmem_ack = 1'b0;
      next_idle();
      e_stall = 1'b1;
      n_req = 1'b1;  n_dm_chk = 1'b1;  n_we = 1'b0;  n_addr = addr;  n_wdata = EX_MEM_B;
      for (int w = 0; w <= r; w++) begin
         tick();
         dmem_ack = 1'b0;
         next_idle();
         if (w == r) begin
            reset_n = 1'b0;
            e_stall = 1'b0;
            next_reset();
            return;
         end
         e_stall = 1'b1;
         n_req = 1'b1;  n_dm_chk = 1'b1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      logic [5:0] alu_ops [6];
      alu_ops = '{OP_ADD, OP_ORI, OP_LUI, OP_BEQ, OP_J_INST, OP_ADD};
      reset_n = 1'b0;
      EX_MEM_valid = 1'b0;  EX_MEM_op = '0;  EX_MEM_instruc_type = '0;
      EX_MEM_result = '0;  EX_MEM_B = '0;  EX_MEM_dest = '0;
      dmem_ack = 1'b0;  dmem_rdata = '0;
      next_reset();
      do_reset(3);

      // add r3 <- 5
      s0 = stall_seen;
      alu_cycle(1'b1, OP_ADD, TYPE_R, 32'h5, 5'd3, 1'b0);
      bubble(1'b0);
      @(negedge clock); #1;
      chk("add_valid", 32'(MEM_WB_valid), 32'd1);
      chk("add_dest", 32'(MEM_WB_dest), 32'd3);
      chk("add_result", MEM_WB_result, 32'h5);
      chk("add_stall_cycles", 32'(stall_seen - s0), 32'd0);

      // lw r8 from 0x100, ack 3 cycles after req
      s0 = stall_seen;
      mem_op(1'b0, 32'h100, 32'h0, 5'd8, 3, 32'hDEADBEEF, 1'b0);
      chk("lw_req", 32'(dmem_req), 32'd1);
      chk("lw_we", 32'(dmem_we), 32'd0);
      chk("lw_addr", dmem_addr, 32'h100);
      bubble(1'b0);
      @(negedge clock); #1;
      chk("lw_valid", 32'(MEM_WB_valid), 32'd1);
      chk("lw_dest", 32'(MEM_WB_dest), 32'd8);
      chk("lw_result", MEM_WB_result, 32'hDEADBEEF);
      chk("lw_req_after", 32'(dmem_req), 32'd0);
      chk("lw_stall_cycles", 32'(stall_seen - s0), 32'd4);

      // sw 0x12345678 to 0x104, ack same cycle as req
      s0 = stall_seen;
      mem_op(1'b1, 32'h104, 32'h12345678, 5'd9, 0, 32'h0, 1'b1);
      chk("sw_we", 32'(dmem_we), 32'd1);
      chk("sw_wdata", dmem_wdata, 32'h12345678);
      bubble(1'b0);
      @(negedge clock); #1;
      chk("sw_valid", 32'(MEM_WB_valid), 32'd0);
      chk("sw_result", MEM_WB_result, 32'h0);
      chk("sw_stall_cycles", 32'(stall_seen - s0), 32'd1);

      // misaligned lw
      s0 = stall_seen;
      mem_op(1'b0, 32'h102, 32'h0, 5'd4, 0, 32'h0, 1'b0);
      #1;
      chk("mis_stall_now", 32'(mem_stall_c), 32'd0);
      bubble(1'b0);
      @(negedge clock); #1;
      chk("mis_fault", 32'(mem_fault_c), 32'd1);
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_valid", 32'(MEM_WB_valid), 32'd0);
      bubble(1'b0);
      @(negedge clock); #1;
      chk("mis_fault_end", 32'(mem_fault_c), 32'd0);

      // lw with no ack: timeout, then a late ack is ignored
      s0 = stall_seen;
      mem_op(1'b0, 32'h200, 32'h0, 5'd5, 99, 32'h0, 1'b0);
      bubble(1'b1);
      @(negedge clock); #1;
      chk("to_fault", 32'(mem_fault_c), 32'd1);
      chk("to_req", 32'(dmem_req), 32'd0);
      chk("to_valid", 32'(MEM_WB_valid), 32'd0);
      chk("to_stall_cycles", 32'(stall_seen - s0), 32'd4);
      bubble(1'b1);
      @(negedge clock); #1;
      chk("to_late_ack_valid", 32'(MEM_WB_valid), 32'd0);
      chk("to_late_ack_req", 32'(dmem_req), 32'd0);

      // jump never writes back
      alu_cycle(1'b1, OP_J_INST, TYPE_J, 32'h40, 5'd31, 1'b0);
      bubble(1'b0);
      @(negedge clock); #1;
      chk("j_valid", 32'(MEM_WB_valid), 32'd0);

      // reset during WAIT of a lw, then an ack after reset
      mem_reset(32'h300, 5'd7, 1);
      #1;
      chk("rst_stall_now", 32'(mem_stall_c), 32'd0);
      bubble(1'b1);
      @(negedge clock); #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_valid", 32'(MEM_WB_valid), 32'd0);
      chk("rst_result", MEM_WB_result, 32'h0);
      chk("rst_fault", 32'(mem_fault_c), 32'd0);
      bubble(1'b1);
      @(negedge clock); #1;
      chk("rst_ack_valid", 32'(MEM_WB_valid), 32'd0);

      // randomized instruction stream
      for (int it = 0; it < 400; it++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel <= 3) begin
            logic v;
            logic [5:0] op;
            v  = ($urandom_range(0, 3) != 0);
            op = alu_ops[$urandom_range(0, 5)];
            if (!v && ($urandom_range(0, 1) == 1)) op = ($urandom_range(0, 1) == 1) ? OP_LW : OP_SW;
            alu_cycle(v, op, 2'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
         end else if (sel <= 7) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            mem_op(1'($urandom_range(0, 1)), a, $urandom, 5'($urandom),
                   $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 1)));
         end else if (sel == 8) begin
            mem_reset($urandom & 32'hFFFF_FFFC, 5'($urandom), $urandom_range(0, TO - 2));
         end else begin
            do_reset(1);
         end
      end
      bubble(1'b0);
      bubble(1'b0);
      @(negedge clock); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
